// File: rtl/pattern_gen_if.sv
// Pixel-side bundle for pattern_gen: timing/coordinate/switch inputs and the registered colour outputs.
interface pattern_gen_if #(
    parameter int COUNTER_BITS = 10,
    parameter int COLOR_BITS   = 8
);
    logic                    bright;
    logic                    red_switch;
    logic                    green_switch;
    logic                    blue_switch;
    logic [1:0]              mode;
    logic                    frame_start;
    logic [COUNTER_BITS-1:0] h_count;
    logic [COUNTER_BITS-1:0] v_count;
    logic [COLOR_BITS-1:0]   red_out;
    logic [COLOR_BITS-1:0]   green_out;
    logic [COLOR_BITS-1:0]   blue_out;

    modport master (
        output bright, red_switch, green_switch, blue_switch, mode, frame_start, h_count, v_count,
        input  red_out, green_out, blue_out
    );

    modport slave (
        input  bright, red_switch, green_switch, blue_switch, mode, frame_start, h_count, v_count,
        output red_out, green_out, blue_out
    );
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern generator: solid, colour bars, checkerboard and a bouncing box, one-clock registered output.
module pattern_gen #(
    parameter int COUNTER_BITS = 10,
    parameter int COLOR_BITS   = 8,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BOX_SIZE     = 32,
    parameter int CHECK_SHIFT  = 5
) (
    input logic          clk,
    input logic          reset,
    pattern_gen_if.slave bus
);
    localparam logic [COUNTER_BITS-1:0] X_MAX = COUNTER_BITS'(H_ACTIVE - BOX_SIZE);
    localparam logic [COUNTER_BITS-1:0] Y_MAX = COUNTER_BITS'(V_ACTIVE - BOX_SIZE);
    localparam logic [COUNTER_BITS-1:0] BAR_W = COUNTER_BITS'(H_ACTIVE / 8);
    localparam logic [COUNTER_BITS:0]   BOX_W = (COUNTER_BITS+1)'(BOX_SIZE);
    localparam logic [1:0] M_SOLID = 2'd0, M_BARS = 2'd1, M_CHECK = 2'd2, M_BOX = 2'd3;

    logic [1:0]              active_mode_q, active_mode_d;
    logic [COUNTER_BITS-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic                    dir_x_q, dir_x_d, dir_y_q, dir_y_d;  // 1 = increasing
    logic [COLOR_BITS-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic [2:0]              sw_rgb, rgb;
    logic [COUNTER_BITS-1:0] bar_k;
    logic [COUNTER_BITS:0]   x_end, y_end;
    logic                    in_box;

    assign sw_rgb = {bus.red_switch, bus.green_switch, bus.blue_switch};
    assign bar_k  = bus.h_count / BAR_W;
    assign x_end  = {1'b0, box_x_q} + BOX_W;
    assign y_end  = {1'b0, box_y_q} + BOX_W;
    assign in_box = (bus.h_count >= box_x_q) && ({1'b0, bus.h_count} < x_end) &&
                    (bus.v_count >= box_y_q) && ({1'b0, bus.v_count} < y_end);

    // Box moves on the current (pre-latch) mode, so entering mode 3 never moves it on the same edge.
    always_comb begin
        active_mode_d = bus.frame_start ? bus.mode : active_mode_q;
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (bus.frame_start && active_mode_q == M_BOX) begin
            if (dir_x_q && box_x_q == X_MAX) begin
                dir_x_d = 1'b0;
                box_x_d = X_MAX - 1'b1;
            end else if (!dir_x_q && box_x_q == '0) begin
                dir_x_d = 1'b1;
                box_x_d = COUNTER_BITS'(1);
            end else begin
                box_x_d = dir_x_q ? box_x_q + 1'b1 : box_x_q - 1'b1;
            end
            if (dir_y_q && box_y_q == Y_MAX) begin
                dir_y_d = 1'b0;
                box_y_d = Y_MAX - 1'b1;
            end else if (!dir_y_q && box_y_q == '0) begin
                dir_y_d = 1'b1;
                box_y_d = COUNTER_BITS'(1);
            end else begin
                box_y_d = dir_y_q ? box_y_q + 1'b1 : box_y_q - 1'b1;
            end
        end
    end

    always_comb begin
        rgb = 3'b000;
        case (active_mode_q)
            M_SOLID: rgb = sw_rgb;
            M_BARS:  rgb = (bar_k < COUNTER_BITS'(8)) ? bar_k[2:0] : 3'b000;
            M_CHECK: rgb = (bus.h_count[CHECK_SHIFT] ^ bus.v_count[CHECK_SHIFT]) ? 3'b111 : sw_rgb;
            M_BOX:   rgb = in_box ? ((sw_rgb == 3'b000) ? 3'b111 : sw_rgb) : 3'b000;
            default: rgb = 3'b000;
        endcase
        if (!bus.bright) rgb = 3'b000;
        red_d   = {COLOR_BITS{rgb[2]}};
        green_d = {COLOR_BITS{rgb[1]}};
        blue_d  = {COLOR_BITS{rgb[0]}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_mode_q <= M_SOLID;
            box_x_q       <= '0;
            box_y_q       <= '0;
            dir_x_q       <= 1'b1;
            dir_y_q       <= 1'b1;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
        end else begin
            active_mode_q <= active_mode_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            dir_x_q       <= dir_x_d;
            dir_y_q       <= dir_y_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign bus.red_out   = red_q;
    assign bus.green_out = green_q;
    assign bus.blue_out  = blue_q;
endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: hand-computed colours and box positions.
module tb_pattern_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   range_err = 0;

    pattern_gen_if #(.COUNTER_BITS(10), .COLOR_BITS(8)) bus ();
    pattern_gen dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb_out();
        return {bus.red_out, bus.green_out, bus.blue_out};
    endfunction

    task automatic set_px(input int h, input int v);
        bus.h_count = 10'(h);
        bus.v_count = 10'(v);
    endtask

    task automatic set_sw(input logic [2:0] s);
        {bus.red_switch, bus.green_switch, bus.blue_switch} = s;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rgb"},  32'(rgb_out()), 32'h0);
        check({tag, "_mode"}, 32'(dut.active_mode_q), 32'd0);
        check({tag, "_bx"},   32'(dut.box_x_q), 32'd0);
        check({tag, "_by"},   32'(dut.box_y_q), 32'd0);
        check({tag, "_dirs"}, 32'({dut.dir_x_q, dut.dir_y_q}), 32'b11);
    endtask

    int          bar_h[5]   = '{0, 80, 560, 639, 640};
    logic [23:0] bar_exp[5] = '{24'h000000, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};

    initial begin
        bus.bright = 1'b0; bus.mode = 2'd0; bus.frame_start = 1'b0;
        set_sw(3'b000); set_px(0, 0);
        step(); step();
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b0;

        // Solid colour, then blanking
        set_sw(3'b101); bus.bright = 1'b1;
        step();
        check("solid_101", 32'(rgb_out()), 32'hFFFFFF & 32'hFF00FF);
        bus.bright = 1'b0;
        step();
        check("blank", 32'(rgb_out()), 32'h0);

        // Colour bars
        bus.bright = 1'b1; bus.mode = 2'd1; bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_px(bar_h[i], 0);
            step();
            check($sformatf("bars_h%0d", bar_h[i]), 32'(rgb_out()), 32'(bar_exp[i]));
        end

        // Back to solid, then a mid-frame request for checkerboard
        bus.mode = 2'd0; bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0; bus.mode = 2'd2; set_px(32, 0);
        step();
        check("midframe_hold", 32'(rgb_out()), 32'hFF00FF);
        bus.frame_start = 1'b1;
        step();
        check("latch_edge_old", 32'(rgb_out()), 32'hFF00FF);
        bus.frame_start = 1'b0;
        step();
        check("check_32_0", 32'(rgb_out()), 32'hFFFFFF);
        set_px(0, 0);
        step();
        check("check_0_0", 32'(rgb_out()), 32'hFF00FF);
        set_sw(3'b010); set_px(32, 32);
        step();
        check("check_32_32", 32'(rgb_out()), 32'h00FF00);

        // Enter box mode: the latching edge must not move the box
        bus.mode = 2'd3; bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        check("enter3_nomove", 32'({dut.box_x_q, dut.box_y_q}), 32'h0);
        for (int f = 1; f <= 700; f++) begin
            bus.frame_start = 1'b1;
            step();
            bus.frame_start = 1'b0;
            if (dut.box_x_q > 10'd608 || dut.box_y_q > 10'd448) range_err++;
            if (f == 1)   check("bx_f1",   32'(dut.box_x_q), 32'd1);
            if (f == 448) check("by_f448", 32'(dut.box_y_q), 32'd448);
            if (f == 449) check("by_f449", 32'(dut.box_y_q), 32'd447);
            if (f == 608) check("bx_f608", 32'(dut.box_x_q), 32'd608);
            if (f == 609) check("bx_f609", 32'(dut.box_x_q), 32'd607);
            step();
        end
        check("box_range", 32'(range_err), 32'd0);
        check("bx_f700", 32'(dut.box_x_q), 32'd516);
        check("by_f700", 32'(dut.box_y_q), 32'd196);

        // Box rendering at (516,196)
        set_sw(3'b000); set_px(516, 196);
        step();
        check("box_tl_white", 32'(rgb_out()), 32'hFFFFFF);
        set_px(515, 196);
        step();
        check("box_left_out", 32'(rgb_out()), 32'h0);
        set_px(547, 227);
        step();
        check("box_br_in", 32'(rgb_out()), 32'hFFFFFF);
        set_px(548, 227);
        step();
        check("box_right_out", 32'(rgb_out()), 32'h0);
        set_px(530, 228);
        step();
        check("box_below_out", 32'(rgb_out()), 32'h0);
        set_sw(3'b100); set_px(530, 210);
        step();
        check("box_sw_red", 32'(rgb_out()), 32'hFF0000);

        // Asynchronous reset mid-cycle
        set_sw(3'b111);
        step();
        check("pre_reset_on", 32'(rgb_out()), 32'hFFFFFF);
        #2 reset = 1'b1;
        #1;
        check_reset_state("async_rst");

        // Reset wins over a simultaneous frame_start
        bus.mode = 2'd3; bus.frame_start = 1'b1;
        step();
        check_reset_state("rst_fs");
        @(negedge clk);
        reset = 1'b0;
        step();
        check("relatch3_nomove", 32'({dut.box_x_q, dut.box_y_q}), 32'h0);
        check("relatch3_mode", 32'(dut.active_mode_q), 32'd3);
        step();
        check("first_move", 32'({dut.box_x_q, dut.box_y_q}), 32'((1 << 10) | 1));
        bus.frame_start = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 Parameter COUNTER_BITS, default 10, SHALL set the h_count/v_count width.
REQ-002 Parameter COLOR_BITS, default 8, SHALL set the width of each colour output.
REQ-003 Parameter H_ACTIVE, default 640, SHALL set the visible pixels per line.
REQ-004 Parameter V_ACTIVE, default 480, SHALL set the visible lines per frame.
REQ-005 Parameter BOX_SIZE, default 32, SHALL set the bouncing-box edge length in pixels.
REQ-006 Parameter CHECK_SHIFT, default 5, SHALL select the checkerboard cell size as 2^CHECK_SHIFT pixels.
REQ-007 Port clk, input, 1, SHALL be the pixel clock; all state changes on its rising edge.
REQ-008 Port reset, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-009 Port bright, input, 1, SHALL be high when h_count/v_count address a visible pixel.
REQ-010 Ports red_switch, green_switch, blue_switch, input, 1 each, SHALL supply the user colour.
REQ-011 Port mode, input, 2, SHALL request the pattern: 0 solid, 1 colour bars, 2 checkerboard, 3 bouncing box.
REQ-012 Port frame_start, input, 1, SHALL be a one-clk pulse marking the start of each frame.
REQ-013 Ports h_count, v_count, input, COUNTER_BITS each, SHALL give the current pixel coordinate.
REQ-014 Ports red_out, green_out, blue_out, output, COLOR_BITS each, SHALL be registered colour outputs.

Function
REQ-015 Each colour channel SHALL be all-ones (ON) or all-zeros (OFF); no intermediate levels.
REQ-016 Outputs SHALL lag bright/h_count/v_count/switches by exactly 1 clk.
REQ-017 When bright is low, all outputs SHALL be OFF on the next clk regardless of mode.
REQ-018 Requested mode SHALL be latched into active_mode only on clk edges where frame_start=1; mid-frame changes SHALL have no visible effect.
REQ-019 Mode 0: each channel SHALL equal ON when its switch is 1, else OFF.
REQ-020 Mode 1: bar index k = h_count / (H_ACTIVE/8); for k in 0..7 SHALL output red=k[2], green=k[1], blue=k[0]; for k>=8 SHALL output OFF.
REQ-021 Mode 2: when h_count[CHECK_SHIFT] XOR v_count[CHECK_SHIFT] = 1, SHALL output all ON; otherwise the mode-0 switch colour.
REQ-022 Mode 3: pixel inside the box (box_x<=h_count<box_x+BOX_SIZE and box_y<=v_count<box_y+BOX_SIZE) SHALL show the switch colour, or all ON if all switches are 0; outside the box SHALL be OFF.
REQ-023 box_x, box_y, dir_x, dir_y SHALL update only on frame_start while active_mode=3; otherwise hold.
REQ-024 On update, box_x SHALL move by 1 in dir_x; box_y likewise in dir_y.
REQ-025 If box_x = H_ACTIVE-BOX_SIZE and dir_x=+, dir_x SHALL flip to - and box_x SHALL become H_ACTIVE-BOX_SIZE-1 in the same update; symmetric at box_x=0 with dir_x=- (flip to +, box_x=1); identical rules for y with V_ACTIVE.
REQ-026 Box coordinates SHALL never leave [0, H_ACTIVE-BOX_SIZE] x [0, V_ACTIVE-BOX_SIZE].
REQ-027 frame_start coinciding with a mode change into 3 SHALL latch mode 3 without moving the box on that same edge.

Reset
REQ-028 While reset=1: outputs OFF, active_mode=0, box_x=0, box_y=0, dir_x=+, dir_y=+.
REQ-029 reset SHALL override a simultaneous frame_start; first box move SHALL occur on the first frame_start after release in mode 3.
REQ-030 Reset asserted mid-frame SHALL force outputs OFF asynchronously, without waiting for clk.

Verification
REQ-031 Mode 0, switches R=1,G=0,B=1, bright=1 -> one clk later red_out=8'hFF, green_out=8'h00, blue_out=8'hFF; drop bright -> all 8'h00 next clk.
REQ-032 Mode 1, h_count=0/80/560/639 -> colours {0,0,0}/{0,0,1}/{1,1,1}/{1,1,1}; h_count=640 with bright=1 -> OFF.
REQ-033 Mode switched 0->2 mid-frame -> output stays mode 0 until after next frame_start, then checkerboard at (32,0)=all ON, (0,0)=switch colour.
REQ-034 Mode 3, 700 frame_start pulses -> box_x reaches 608 at frame 608, then 607 at frame 609; box_y reaches 448, then 447; never out of range.
REQ-035 Assert reset mid-line with box at (100,50) -> outputs 00 immediately, box (0,0), dirs +, active_mode 0.
REQ-036 reset and frame_start asserted on the same edge -> no box movement, state equals REQ-028 values.
